// File: rtl/test_transmit_if.sv
// Host/core-facing signal bundle for the test_transmit packet source.
// master = host + core side (drives strobes/data), slave = the FIFO block.
interface test_transmit_if #(
  parameter int PACKET_WIDTH = 32,
  parameter int DEPTH        = 16,
  parameter int CNT_WIDTH    = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                    wr_en;
  logic [PACKET_WIDTH-1:0] wr_data;
  logic                    send_en;
  logic                    flush;
  logic                    full;
  logic [LVL_W-1:0]        level;
  logic [PACKET_WIDTH-1:0] packet;
  logic                    input_buffer_empty;
  logic                    ren_to_input_buffer;
  logic [CNT_WIDTH-1:0]    sent_count;
  logic                    overflow_err;
  logic                    underflow_err;

  modport master (
    output wr_en, wr_data, send_en, flush, ren_to_input_buffer,
    input  full, level, packet, input_buffer_empty, sent_count,
           overflow_err, underflow_err
  );

  modport slave (
    input  wr_en, wr_data, send_en, flush, ren_to_input_buffer,
    output full, level, packet, input_buffer_empty, sent_count,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/test_transmit.sv
// Host-side packet source: show-ahead FIFO feeding the core's input-buffer port,
// with a sent-packet counter and sticky overflow/underflow flags.
module test_transmit #(
  parameter int PACKET_WIDTH = 32,
  parameter int DEPTH        = 16,
  parameter int CNT_WIDTH    = 16
) (
  input logic            clk,
  input logic            rst,
  test_transmit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PACKET_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [CNT_WIDTH-1:0] sent_count_q, sent_count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic empty_seen, full, pop, push, mem_we;

  // Core sees nothing while paused, even if entries are buffered.
  assign full       = (level_q == LVL_W'(DEPTH));
  assign empty_seen = (level_q == '0) || !bus.send_en;
  assign pop        = bus.ren_to_input_buffer && !empty_seen;
  assign push       = bus.wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    sent_count_d = sent_count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    mem_we       = 1'b0;
    if (bus.flush) begin
      // Flush swallows concurrent strobes silently; error history is kept.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      sent_count_d = '0;
    end else begin
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        sent_count_d = sent_count_q + CNT_WIDTH'(1);
      end
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (bus.ren_to_input_buffer && empty_seen) underflow_d = 1'b1;
      if (bus.wr_en && full && !pop)             overflow_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sent_count_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sent_count_q <= sent_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full               = full;
  assign bus.level              = level_q;
  assign bus.input_buffer_empty = empty_seen;
  assign bus.packet             = (level_q != '0) ? mem[rd_ptr_q] : '0;
  assign bus.sent_count         = sent_count_q;
  assign bus.overflow_err       = overflow_q;
  assign bus.underflow_err      = underflow_q;
endmodule

// File: tb/tb_test_transmit.sv
// Bench for test_transmit: directed vector table, hand-written corner sequences and a
// randomized stream checked against a queue-based reference model.
module tb_test_transmit;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  test_transmit_if #(.PACKET_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)) bus();

  test_transmit #(.PACKET_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic        m_snd = 1'b0;

  typedef struct {
    logic        r, w, s, f, rn;
    logic [31:0] d;
    logic [4:0]  e_lvl;
    logic        e_emp;
    logic [31:0] e_pkt;
    logic [15:0] e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic r, w, s, f, rn, input logic [31:0] d,
                              input logic [4:0] lvl, input logic emp, input logic [31:0] pkt,
                              input logic [15:0] cnt, input logic ovf, unf);
    vec_t v;
    v.r = r; v.w = w; v.s = s; v.f = f; v.rn = rn; v.d = d;
    v.e_lvl = lvl; v.e_emp = emp; v.e_pkt = pkt; v.e_cnt = cnt;
    v.e_ovf = ovf; v.e_unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then step past the clock edge.
  task automatic tick(input logic r, w, s, f, rn, input logic [31:0] d);
    logic emp_seen;
    rst = r;
    bus.wr_en = w; bus.wr_data = d; bus.send_en = s;
    bus.flush = f; bus.ren_to_input_buffer = rn;
    m_snd = s;
    if (r) begin
      mq.delete(); m_cnt = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (f) begin
      mq.delete(); m_cnt = '0;
    end else begin
      emp_seen = (mq.size() == 0) || !s;
      if (rn && emp_seen) m_unf = 1'b1;
      if (rn && !emp_seen) begin
        chk("pop_data", bus.packet, mq[0]);
        void'(mq.pop_front());
        m_cnt++;
      end
      if (w) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 32'(mq.size()));
    chk({tag, "_full"},  32'(bus.full), 32'(mq.size() == DEPTH));
    chk({tag, "_empty"}, 32'(bus.input_buffer_empty), 32'((mq.size() == 0) || !m_snd));
    chk({tag, "_packet"}, bus.packet, (mq.size() != 0) ? mq[0] : 32'h0);
    chk({tag, "_count"}, 32'(bus.sent_count), 32'(m_cnt));
    chk({tag, "_ovf"},   32'(bus.overflow_err), 32'(m_ovf));
    chk({tag, "_unf"},   32'(bus.underflow_err), 32'(m_unf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last;
    int          n_wr;
    logic        w, rn, s;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.send_en = 1'b0;
    bus.flush = 1'b0; bus.ren_to_input_buffer = 1'b0;

    //                r     w     s     f     rn    data          lvl   emp   pkt           cnt    ovf   unf
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 32'h0,        16'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A50001, 5'd1, 1'b0, 32'hA5A50001, 16'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        5'd0, 1'b1, 32'h0,        16'd1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        5'd0, 1'b1, 32'h0,        16'd1, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11,       5'd1, 1'b0, 32'h11,       16'd1, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h22,       5'd2, 1'b0, 32'h11,       16'd1, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33,       5'd3, 1'b1, 32'h11,       16'd1, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        5'd3, 1'b1, 32'h11,       16'd1, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h77,       5'd0, 1'b1, 32'h0,        16'd0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44,       5'd1, 1'b0, 32'h44,       16'd0, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 32'h0,        16'd0, 1'b0, 1'b0);

    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].r, tbl[i].w, tbl[i].s, tbl[i].f, tbl[i].rn, tbl[i].d);
      chk($sformatf("vec%0d_level", i),  32'(bus.level), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d_empty", i),  32'(bus.input_buffer_empty), 32'(tbl[i].e_emp));
      chk($sformatf("vec%0d_packet", i), bus.packet, tbl[i].e_pkt);
      chk($sformatf("vec%0d_count", i),  32'(bus.sent_count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_ovf", i),    32'(bus.overflow_err), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_unf", i),    32'(bus.underflow_err), 32'(tbl[i].e_unf));
    end

    // Fill while paused, overflow, then drain in order
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd16);
    chk("fill_empty", 32'(bus.input_buffer_empty), 32'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
    chk("ovf_flag", 32'(bus.overflow_err), 32'd1);
    chk("ovf_level", 32'(bus.level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", bus.packet, 32'(i));
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    end
    chk("drain_count", 32'(bus.sent_count), 32'd16);
    chk("drain_empty", 32'(bus.input_buffer_empty), 32'd1);

    // Full FIFO with simultaneous write and pop
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h99);
    chk("fullrw_level", 32'(bus.level), 32'd16);
    chk("fullrw_ovf", 32'(bus.overflow_err), 32'd0);
    last = 32'h0;
    for (int i = 0; i < 16; i++) begin
      last = bus.packet;
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    end
    chk("fullrw_last", last, 32'h99);
    check_model("fullrw_end");

    // Flush keeps error flags
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500 + 32'(i));
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("preflush_count", 32'(bus.sent_count), 32'd2);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_level", 32'(bus.level), 32'd0);
    chk("flush_empty", 32'(bus.input_buffer_empty), 32'd1);
    chk("flush_count", 32'(bus.sent_count), 32'd0);
    chk("flush_unf", 32'(bus.underflow_err), 32'd1);
    chk("flush_ovf", 32'(bus.overflow_err), 32'd0);

    // Randomized 40-packet stream with pointer wrap
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_wr = 0;
    for (int cyc = 0; cyc < 3000 && m_cnt < 16'd40; cyc++) begin
      w  = (n_wr < 40) && (mq.size() < DEPTH) && ($urandom % 3 != 0);
      rn = ($urandom % 2) == 1;
      s  = ($urandom % 8) != 0;
      tick(1'b0, w, s, 1'b0, rn, {16'($urandom), 16'(n_wr)});
      if (w) n_wr++;
      check_model("stream");
    end
    chk("stream_count", 32'(bus.sent_count), 32'd40);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF);
    chk("midrst_level", 32'(bus.level), 32'd0);
    chk("midrst_empty", 32'(bus.input_buffer_empty), 32'd1);
    chk("midrst_packet", bus.packet, 32'h0);
    check_model("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
